// File: rtl/ts_tx_pkg.sv
// Shared constants, types and helpers for the timestamp UART transmitter.
// Optional feature macro: TS_TX_PARITY_EN (even parity bit per character).
package ts_tx_pkg;

    localparam int         FRAME_LEN = 21;
    localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);

    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_BAD   = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } ts_state_e;

    typedef struct packed {
        logic [3:0] yr_th;
        logic [3:0] yr_hu;
        logic [3:0] yr_te;
        logic [3:0] yr_un;
        logic [3:0] mon_te;
        logic [3:0] mon_un;
        logic [3:0] d_te;
        logic [3:0] d_un;
        logic [3:0] hr_te;
        logic [3:0] hr_un;
        logic [3:0] min_te;
        logic [3:0] min_un;
        logic [3:0] sec_te;
        logic [3:0] sec_un;
    } ts_snap_t;

    // Non-decimal nibbles are shown as '?' so a corrupt counter is visible on the host.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        logic [7:0] res;
        if (d <= 4'd9) begin
            res = ASC_ZERO + {4'd0, d};
        end else begin
            res = ASC_BAD;
        end
        return res;
    endfunction

`ifdef TS_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser: start bit, 8 data bits LSB first, optional
// even parity (TS_TX_PARITY_EN), stop bit; every bit held DIV clocks.
module uart_tx_byte
    import ts_tx_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
`ifdef TS_TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif

    logic          r_active;
    logic [CW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [7:0]    r_data;
    logic          r_tx;

    logic          w_wrap;
    logic          w_last;
    logic          w_accept;
    logic          w_next_tx;

    assign w_wrap   = r_active && (r_baud == CW'(DIV - 1));
    assign w_last   = w_wrap && (r_bit == LAST_BIT);
    // Ready already in the final stop-bit cycle keeps the inter-character gap to one idle cycle.
    assign ready    = !r_active || w_last;
    assign w_accept = valid && ready;
    assign tx       = r_tx;

    // Line level for the bit that follows the current one.
    always_comb begin
        w_next_tx = 1'b1;
        if (r_bit < 4'd8) begin
            w_next_tx = r_data[r_bit[2:0]];
`ifdef TS_TX_PARITY_EN
        end else if (r_bit == 4'd8) begin
            w_next_tx = even_parity(r_data);
`endif
        end else begin
            w_next_tx = 1'b1;
        end
    end

    // Baud counter, bit counter and line register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_data   <= 8'd0;
            r_tx     <= 1'b1;
        end else if (w_accept) begin
            r_active <= 1'b1;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_data   <= data;
            r_tx     <= 1'b0;
        end else if (w_last) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_tx     <= 1'b1;
        end else if (w_wrap) begin
            r_baud   <= '0;
            r_bit    <= r_bit + 4'd1;
            r_tx     <= w_next_tx;
        end else if (r_active) begin
            r_baud   <= r_baud + CW'(1);
        end else begin
            r_baud   <= '0;
        end
    end

endmodule

// File: rtl/timestamp_uart_tx.sv
// Sends a captured date/time snapshot as "YYYY-MM-DD hh:mm:ss\r\n" over UART.
// Optional feature macro: TS_TX_PARITY_EN (8E1 instead of 8N1).
module timestamp_uart_tx
    import ts_tx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] yr_thousands,
    input  logic [3:0] yr_hundreds,
    input  logic [3:0] yr_tens,
    input  logic [3:0] yr_units,
    input  logic [3:0] mon_tens,
    input  logic [3:0] mon_units,
    input  logic [3:0] d_tens,
    input  logic [3:0] d_units,
    input  logic [3:0] hr_tens,
    input  logic [3:0] hr_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_units,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // Truncated divisor; must come out at 2 or more.
    localparam int DIV = CLK_HZ / BAUD;

    ts_state_e  r_state;
    logic [4:0] r_idx;
    ts_snap_t   r_snap;
    logic       r_busy;
    logic       r_done;

    ts_snap_t   w_live;
    logic       w_valid;
    logic       w_ready;
    logic       w_tx;
    logic [7:0] w_byte;

    function automatic logic [7:0] char_at(input logic [4:0] idx, input ts_snap_t s);
        logic [7:0] c;
        case (idx)
            5'd0:    c = digit_ascii(s.yr_th);
            5'd1:    c = digit_ascii(s.yr_hu);
            5'd2:    c = digit_ascii(s.yr_te);
            5'd3:    c = digit_ascii(s.yr_un);
            5'd4:    c = ASC_DASH;
            5'd5:    c = digit_ascii(s.mon_te);
            5'd6:    c = digit_ascii(s.mon_un);
            5'd7:    c = ASC_DASH;
            5'd8:    c = digit_ascii(s.d_te);
            5'd9:    c = digit_ascii(s.d_un);
            5'd10:   c = ASC_SPACE;
            5'd11:   c = digit_ascii(s.hr_te);
            5'd12:   c = digit_ascii(s.hr_un);
            5'd13:   c = ASC_COLON;
            5'd14:   c = digit_ascii(s.min_te);
            5'd15:   c = digit_ascii(s.min_un);
            5'd16:   c = ASC_COLON;
            5'd17:   c = digit_ascii(s.sec_te);
            5'd18:   c = digit_ascii(s.sec_un);
            5'd19:   c = ASC_CR;
            5'd20:   c = ASC_LF;
            default: c = ASC_BAD;
        endcase
        return c;
    endfunction

    assign w_live = {yr_thousands, yr_hundreds, yr_tens, yr_units,
                     mon_tens, mon_units, d_tens, d_units,
                     hr_tens, hr_units, min_tens, min_units,
                     sec_tens, sec_units};

    assign w_valid = (r_state == ST_LOAD);
    assign w_byte  = char_at(r_idx, r_snap);
    assign tx      = w_tx;
    assign busy    = r_busy;
    assign done    = r_done;

    uart_tx_byte #(
        .DIV (DIV)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .data  (w_byte),
        .valid (w_valid),
        .ready (w_ready),
        .tx    (w_tx)
    );

    // Frame sequencer: snapshot on start, walk the 21 characters, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 5'd0;
            r_snap  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap  <= w_live;
                        r_idx   <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (w_ready) begin
                        r_state <= ST_SEND;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_SEND: begin
                    if (!w_ready) begin
                        r_state <= ST_SEND;
                    end else if (r_idx == LAST_IDX) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx   <= r_idx + 5'd1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timestamp_uart_tx.sv
// Randomised self-checking bench for timestamp_uart_tx: a line decoder turns
// tx back into bytes, compared with a text model of the expected timestamp.
module tb_timestamp_uart_tx;

    localparam int DIV = 10;
`ifdef TS_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dig [14];
    logic       tx, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int bit_err = 0, stop_err = 0, par_err = 0;

    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    int         rx_start_q[$];

    logic [3:0] cap [14];
    logic [7:0] exp_b [21];

    timestamp_uart_tx #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk(clk), .rst(rst), .start(start),
        .yr_thousands(dig[0]), .yr_hundreds(dig[1]), .yr_tens(dig[2]), .yr_units(dig[3]),
        .mon_tens(dig[4]), .mon_units(dig[5]), .d_tens(dig[6]), .d_units(dig[7]),
        .hr_tens(dig[8]), .hr_units(dig[9]), .min_tens(dig[10]), .min_units(dig[11]),
        .sec_tens(dig[12]), .sec_units(dig[13]),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder: every bit must stay constant for DIV samples.
    initial begin : line_monitor
        logic [10:0] bits;
        bit abort;
        int t0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                t0 = cyc;
                abort = 1'b0;
                bits = '0;
                for (int b = 0; b < NBITS && !abort; b++) begin
                    for (int k = 0; k < DIV && !abort; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst !== 1'b0) abort = 1'b1;
                        else if (k == 0) bits[b] = tx;
                        else if (tx !== bits[b]) bit_err++;
                    end
                end
                if (!abort) begin
                    rx_q.push_back(bits[8:1]);
                    rx_start_q.push_back(t0);
                    if (bits[NBITS-1] !== 1'b1) stop_err++;
`ifdef TS_TX_PARITY_EN
                    rx_par_q.push_back(bits[9]);
                    if (bits[9] !== ^bits[8:1]) par_err++;
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // Expected text: template with digit positions filled, then CR LF.
    task automatic build_expected();
        string s;
        int pos [14];
        byte c;
        pos = '{0, 1, 2, 3, 5, 6, 8, 9, 11, 12, 14, 15, 17, 18};
        s = "0000-00-00 00:00:00";
        for (int k = 0; k < 14; k++) begin
            c = (cap[k] < 4'd10) ? byte'(48 + int'(cap[k])) : byte'("?");
            s.putc(pos[k], c);
        end
        for (int i = 0; i < 19; i++) exp_b[i] = s.getc(i);
        exp_b[19] = 8'h0D;
        exp_b[20] = 8'h0A;
    endtask

    task automatic pulse_start();
        for (int k = 0; k < 14; k++) cap[k] = dig[k];
        build_expected();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val($sformatf("%s_done_seen", tag), done, 1'b1);
        check_val($sformatf("%s_busy_low_on_done", tag), busy, 1'b0);
    endtask

    task automatic check_frame(input int base, input string tag);
        int g0, nbad;
        check_val($sformatf("%s_len", tag), rx_q.size(), base + 21);
        if (rx_q.size() >= base + 21) begin
            for (int i = 0; i < 21; i++)
                check_val($sformatf("%s_byte%0d", tag, i), rx_q[base + i], exp_b[i]);
            g0 = rx_start_q[base + 1] - rx_start_q[base] - NBITS * DIV;
            nbad = 0;
            for (int i = 1; i < 20; i++)
                if (rx_start_q[base + i + 1] - rx_start_q[base + i] - NBITS * DIV != g0) nbad++;
            check_val($sformatf("%s_gap_le1", tag), (g0 == 0 || g0 == 1), 1'b1);
            check_val($sformatf("%s_gap_const", tag), nbad, 0);
        end
    endtask

    task automatic randomize_digits();
        for (int k = 0; k < 14; k++)
            dig[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    endtask

    initial begin : main
        int n, lat, dc0;
        logic [3:0] init_d [14];
        init_d = '{4'd2, 4'd0, 4'd2, 4'd5, 4'd0, 4'd3, 4'd0, 4'd7, 4'd1, 4'd4, 4'd0, 4'd5, 4'd0, 4'd9};
        for (int k = 0; k < 14; k++) dig[k] = init_d[k];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_tx", tx, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        check_val("idle_1000", n, 0);

        // Full frame 2025-03-07 14:05:09
        rx_q.delete(); rx_start_q.delete(); rx_par_q.delete();
        dc0 = done_cnt;
        pulse_start();
        check_val("busy_latency", busy, 1'b1);
        lat = 0;
        while (tx !== 1'b0 && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        check_val("start_bit_latency", (lat >= 1 && lat <= 2), 1'b1);
        wait_done("full");
        check_frame(0, "full");
        @(negedge clk);
        check_val("done_one_cycle", done, 1'b0);
        check_val("full_done_count", done_cnt - dc0, 1);
`ifdef TS_TX_PARITY_EN
        if (rx_par_q.size() >= 21) begin
            check_val("parity_of_7", rx_par_q[9], 1'b1);
            check_val("parity_of_0", rx_par_q[1], 1'b0);
        end
`endif

        // Second start mid-frame is dropped
        repeat (5) @(negedge clk);
        rx_q.delete(); rx_start_q.delete(); rx_par_q.delete();
        randomize_digits();
        dc0 = done_cnt;
        pulse_start();
        repeat (49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_rej");
        check_frame(0, "busy_rej");
        repeat (300) @(negedge clk);
        check_val("busy_rej_bytes", rx_q.size(), 21);
        check_val("busy_rej_done_count", done_cnt - dc0, 1);

        // Start on the done cycle gives back-to-back frames
        rx_q.delete(); rx_start_q.delete(); rx_par_q.delete();
        randomize_digits();
        pulse_start();
        wait_done("b2b_first");
        check_frame(0, "b2b_first");
        randomize_digits();
        pulse_start();
        check_val("b2b_busy_again", busy, 1'b1);
        wait_done("b2b_second");
        check_frame(21, "b2b_second");

        // Invalid digit and mid-frame input change
        repeat (5) @(negedge clk);
        rx_q.delete(); rx_start_q.delete(); rx_par_q.delete();
        randomize_digits();
        dig[3] = 4'd6;
        dig[13] = 4'hC;
        pulse_start();
        repeat (50) @(negedge clk);
        dig[3] = 4'd1;
        wait_done("snap");
        check_frame(0, "snap");
        if (rx_q.size() >= 21) begin
            check_val("snap_bad_digit", rx_q[18], 8'h3F);
            check_val("snap_year_units", rx_q[3], 8'h36);
        end

        // Reset during char 5
        repeat (5) @(negedge clk);
        rx_q.delete(); rx_start_q.delete(); rx_par_q.delete();
        randomize_digits();
        pulse_start();
        n = 0;
        while (rx_q.size() < 5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_reach_char5", (rx_q.size() >= 5), 1'b1);
        repeat (30) @(negedge clk);
        dc0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_tx", tx, 1'b1);
        check_val("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check_val("mid_rst_no_done", done_cnt - dc0, 0);
        check_val("mid_rst_bytes", rx_q.size(), 5);
        rx_q.delete(); rx_start_q.delete(); rx_par_q.delete();
        randomize_digits();
        pulse_start();
        wait_done("after_rst");
        check_frame(0, "after_rst");

        // Random frames
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            rx_q.delete(); rx_start_q.delete(); rx_par_q.delete();
            randomize_digits();
            pulse_start();
            wait_done($sformatf("rand%0d", r));
            check_frame(0, $sformatf("rand%0d", r));
        end

        check_val("bit_width_errors", bit_err, 0);
        check_val("stop_bit_errors", stop_err, 0);
        check_val("parity_errors", par_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
